// File: rtl/or_reduce_seq_pkg.sv
// Shared definitions for the sequential OR-reduction engine: state width and encodings.
package or_reduce_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/or_reduce_seq_or_chunk.sv
// Purely combinational C-input OR, built as a chain of gate primitives seeded with 0.
module or_chunk #(
    parameter int C = 4
) (
    input  logic [C-1:0] din,
    output logic         hit
);

    logic [C:0] chain;

    assign chain[0] = 1'b0;

    for (genvar i = 0; i < C; i++) begin : g_or
        or u_or (chain[i+1], chain[i], din[i]);
    end

    assign hit = chain[C];

endmodule

// File: rtl/or_reduce_seq.sv
// Multi-cycle OR-reduction: one shared C-bit reducer walks the accepted word chunk by chunk.
//   state   | meaning
//   IDLE    | waiting for a word, in_ready high
//   SCAN    | reducing one chunk per clock
//   DONE    | result presented, out_valid high until taken
module or_reduce_seq
    import or_reduce_seq_pkg::*;
#(
    parameter  int W          = 16,
    parameter  int C          = 4,
    parameter  int EARLY_EXIT = 1,
    localparam int NCH        = W / C,
    localparam int CW         = $clog2(NCH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          result,
    output logic [CW-1:0] cycles
);

    if (C < 1 || C > W || (W % C) != 0) begin : g_bad_params
        $error("or_reduce_seq: W must be a positive multiple of C");
    end

    state_t        state;
    logic [W-1:0]  sreg;
    logic          acc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          hit;
    logic          last_chunk;

    or_chunk #(.C(C)) u_or_chunk (
        .din (sreg[C-1:0]),
        .hit (hit)
    );

    assign cnt_next   = cnt + 1'b1;
    assign last_chunk = (cnt_next == CW'(NCH)) || ((EARLY_EXIT != 0) && hit);

    // Handshake flags depend on the state register only, never on the inputs.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            acc    <= 1'b0;
            cnt    <= '0;
            result <= 1'b0;
            cycles <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sreg  <= in_data;
                        acc   <= 1'b0;
                        cnt   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    acc  <= acc | hit;
                    sreg <= sreg >> C;
                    cnt  <= cnt_next;
                    if (last_chunk) begin
                        result <= acc | hit;
                        cycles <= cnt_next;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or_reduce_seq.sv
// Directed bench for or_reduce_seq: three configurations checked through an expected-result queue.
module tb_or_reduce_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  orr = '0;
    logic [2:0]  res;
    logic [15:0] dat [3];
    logic [2:0]  cyc_a;
    logic [2:0]  cyc_b;
    logic        cyc_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       res;
        logic [2:0] cyc;
        int         lat;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    // a: W=16 C=4 early exit, b: W=16 C=4 full scan, c: W=C=4
    or_reduce_seq #(.W(16), .C(4), .EARLY_EXIT(1)) dut_a (
        .clk(clk), .reset_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(dat[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .result(res[0]), .cycles(cyc_a));
    or_reduce_seq #(.W(16), .C(4), .EARLY_EXIT(0)) dut_b (
        .clk(clk), .reset_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(dat[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .result(res[1]), .cycles(cyc_b));
    or_reduce_seq #(.W(4), .C(4), .EARLY_EXIT(1)) dut_c (
        .clk(clk), .reset_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(dat[2][3:0]),
        .out_valid(ov[2]), .out_ready(orr[2]), .result(res[2]), .cycles(cyc_c));

    function automatic logic [2:0] cyc_of(int idx);
        case (idx)
            0:       return cyc_a;
            1:       return cyc_b;
            default: return {2'b00, cyc_c};
        endcase
    endfunction

    // Reference: OR of the word; chunk count stops at first nonzero chunk when early exit.
    function automatic exp_t model(logic [15:0] d, int w, int c, bit ee);
        exp_t e;
        int   nch = w / c;
        logic [15:0] m;
        e.res = 1'b0;
        e.cyc = 3'(nch);
        for (int k = 0; k < nch; k++) begin
            m = d >> (k * c);
            if ((m & ((16'd1 << c) - 16'd1)) != 16'd0) begin
                e.res = 1'b1;
                if (ee && (e.cyc == 3'(nch)) && (k + 1 < nch)) e.cyc = 3'(k + 1);
            end
        end
        e.lat = int'(e.cyc);
        return e;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(int idx, logic [15:0] d);
        exp_t e;
        case (idx)
            0:       e = model(d, 16, 4, 1'b1);
            1:       e = model(d, 16, 4, 1'b0);
            default: e = model(d, 4, 4, 1'b1);
        endcase
        sb.push_back(e);
        @(negedge clk);
        chk("in_ready_before_accept", 16'(ir[idx]), 16'd1);
        iv[idx]  = 1'b1;
        dat[idx] = d;
        @(posedge clk);
        #1;
        iv[idx] = 1'b0;
        chk("in_ready_in_scan", 16'(ir[idx]), 16'd0);
    endtask

    task automatic wait_out(int idx);
        int   lat = 0;
        exp_t e;
        while (!ov[idx] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_seen", 16'(ov[idx]), 16'd1);
        chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("latency", 16'(lat), 16'(e.lat));
            chk("result", 16'(res[idx]), 16'(e.res));
            chk("cycles", 16'(cyc_of(idx)), 16'(e.cyc));
        end
    endtask

    task automatic finish_hs(int idx);
        @(posedge clk);
        #1;
        chk("out_valid_one_cycle", 16'(ov[idx]), 16'd0);
        chk("in_ready_after_hs", 16'(ir[idx]), 16'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) dat[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 16'(ir), 16'h7);
        chk("rst_out_valid", 16'(ov), 16'h0);
        chk("rst_result", 16'(res), 16'h0);
        chk("rst_cycles_a", 16'(cyc_a), 16'd0);
        chk("rst_cycles_c", 16'(cyc_c), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        orr   = 3'b111;

        // Early-exit engine
        send(0, 16'h0000); wait_out(0); finish_hs(0);
        send(0, 16'h0010); wait_out(0); finish_hs(0);
        send(0, 16'h8000); wait_out(0); finish_hs(0);
        send(0, 16'h0001); wait_out(0); finish_hs(0);

        // Full-scan engine
        send(1, 16'h8001); wait_out(1); finish_hs(1);
        send(1, 16'h0010); wait_out(1); finish_hs(1);
        send(1, 16'h0000); wait_out(1); finish_hs(1);

        // Single-chunk engine
        send(2, 16'h0001); wait_out(2); finish_hs(2);
        send(2, 16'h0000); wait_out(2); finish_hs(2);

        // Backpressure: result held, new word refused until handshake
        @(negedge clk);
        orr[0] = 1'b0;
        send(0, 16'h0100); wait_out(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv[0]  = ~iv[0];
            dat[0] = 16'h0000;
            @(posedge clk);
            #1;
            chk("bp_out_valid", 16'(ov[0]), 16'd1);
            chk("bp_result", 16'(res[0]), 16'd1);
            chk("bp_cycles", 16'(cyc_a), 16'd3);
            chk("bp_in_ready", 16'(ir[0]), 16'd0);
        end
        @(negedge clk);
        iv[0]  = 1'b1;
        dat[0] = 16'h0000;
        orr[0] = 1'b1;
        sb.push_back(model(16'h0000, 16, 4, 1'b1));
        @(posedge clk);
        #1;
        chk("bp_hs_out_valid", 16'(ov[0]), 16'd0);
        chk("bp_hs_in_ready", 16'(ir[0]), 16'd1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("bp_second_accept", 16'(ir[0]), 16'd0);
        wait_out(0); finish_hs(0);

        // Reset in the middle of a scan drops the word
        send(0, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 16'(ov[0]), 16'd0);
        chk("mid_rst_result", 16'(res[0]), 16'd0);
        chk("mid_rst_cycles", 16'(cyc_a), 16'd0);
        chk("mid_rst_in_ready", 16'(ir[0]), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_out", 16'(ov[0]), 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
